ram_alu_host: RTL and testbench

RAM_ALU_HOST -- requirements
Module: ram_alu_host

---
 rtl/ram_alu_host.sv | 150 +++++++++++++++
 tb/tb_ram_alu_host.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_alu_host.sv
// ram_alu_host: accepts an arithmetic command, writes X and Y into an
// external register-mapped ALU, reads back the 32-bit result and returns
// it over a valid/ready response channel. Illegal commands (divide by
// zero) are answered directly with an error and never touch the ALU bus.
module ram_alu_host #(
  parameter int HOLD_CYCLES = 1,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        alu_e,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_din,
  output logic [1:0]  alu_addr,
  output logic        alu_w,
  output logic        alu_r,
  input  logic [31:0] alu_dout
);

  typedef enum logic [2:0] {IDLE, WR_X, WR_Y, RD, RESP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] READ_LAST = 4'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  alu_op_q;
  logic [15:0] x_q, y_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        accept;
  logic        illegal;
  logic        rd_done;

  assign cmd_ready = (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Operations whose divisor would be zero are rejected up front.
  assign illegal   = (((cmd_op == 2'd1) || (cmd_op == 2'd2)) && (cmd_y == 16'd0)) ||
                     ((cmd_op == 2'd3) && (cmd_x == cmd_y));
  assign rd_done   = (state_q == RD) && (cnt_q == READ_LAST);

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_op    = alu_op_q;

  // State and phase counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state sequencing and ALU bus decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_e    = 1'b0;
    alu_w    = 1'b0;
    alu_r    = 1'b0;
    alu_addr = 2'd0;
    alu_din  = 16'd0;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (accept) state_d = illegal ? RESP : WR_X;
      end
      WR_X: begin
        alu_e    = 1'b1;
        alu_w    = 1'b1;
        alu_addr = 2'd0;
        alu_din  = x_q;
        if (cnt_q == HOLD_LAST) begin
          state_d = WR_Y;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_Y: begin
        alu_e    = 1'b1;
        alu_w    = 1'b1;
        alu_addr = 2'd1;
        alu_din  = y_q;
        if (cnt_q == HOLD_LAST) begin
          state_d = RD;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD: begin
        alu_e    = 1'b1;
        alu_r    = 1'b1;
        alu_addr = 2'd2;
        if (rd_done) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Command latch, ALU op select and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      alu_op_q   <= 2'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        x_q <= cmd_x;
        y_q <= cmd_y;
        if (illegal) begin
          rsp_data_q <= 32'd0;
          rsp_err_q  <= 1'b1;
        end else begin
          alu_op_q  <= cmd_op;
          rsp_err_q <= 1'b0;
        end
      end
      if (rd_done) rsp_data_q <= alu_dout;
    end
  end

endmodule

// File: tb/tb_ram_alu_host.sv
// Bench for ram_alu_host: default-parameter instance for most scenarios and
// a HOLD_CYCLES=3/READ_LAT=2 instance for the stretched-timing case. Each
// instance talks to its own behavioural register-mapped ALU.
module tb_ram_alu_host;

  typedef logic [22:0] bus_t; // {e, op, w, r, addr, din}

  logic        clk, rst, cmd_valid, cmd_valid2, rsp_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_x, cmd_y;

  logic        cmd_ready1, rsp_valid1, rsp_err1, alu_e1, alu_w1, alu_r1;
  logic [31:0] rsp_data1, alu_dout1;
  logic [1:0]  alu_op1, alu_addr1;
  logic [15:0] alu_din1;
  logic        cmd_ready2, rsp_valid2, rsp_err2, alu_e2, alu_w2, alu_r2;
  logic [31:0] rsp_data2, alu_dout2;
  logic [1:0]  alu_op2, alu_addr2;
  logic [15:0] alu_din2;

  int   n_cmp = 0;
  int   n_fail = 0;
  logic sel = 1'b0;
  bus_t bus_q[$];
  bus_t exp_q[$];

  ram_alu_host dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
    .alu_e(alu_e1), .alu_op(alu_op1), .alu_din(alu_din1), .alu_addr(alu_addr1),
    .alu_w(alu_w1), .alu_r(alu_r1), .alu_dout(alu_dout1));

  ram_alu_host #(.HOLD_CYCLES(3), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .alu_e(alu_e2), .alu_op(alu_op2), .alu_din(alu_din2), .alu_addr(alu_addr2),
    .alu_w(alu_w2), .alu_r(alu_r2), .alu_dout(alu_dout2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic meaning of each op on unsigned 16-bit operands.
  function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    longint sx, sy, r;
    sx = x;
    sy = y;
    case (op)
      2'd0:    r = (sx + sy) * (sx - sy);
      2'd1:    r = (sy == 0) ? 0 : sx % sy;
      2'd2:    r = (sy == 0) ? 0 : sx / sy;
      default: r = (sx == sy) ? 0 : sx % (sx - sy);
    endcase
    return r[31:0];
  endfunction

  function automatic logic is_illegal(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    return ((op == 2'd1 || op == 2'd2) && y == 16'd0) || (op == 2'd3 && x == y);
  endfunction

  // Behavioural ALUs: registers X/Y written by strobe, result readable at address 2.
  logic [15:0] ax1, ay1, ax2, ay2;
  always @(posedge clk) begin
    if (alu_e1 && alu_w1 && alu_addr1 == 2'd0) ax1 <= alu_din1;
    if (alu_e1 && alu_w1 && alu_addr1 == 2'd1) ay1 <= alu_din1;
    if (alu_e2 && alu_w2 && alu_addr2 == 2'd0) ax2 <= alu_din2;
    if (alu_e2 && alu_w2 && alu_addr2 == 2'd1) ay2 <= alu_din2;
  end
  assign alu_dout1 = (alu_e1 && alu_r1 && alu_addr1 == 2'd2) ? ref_fn(alu_op1, ax1, ay1) : 32'hDEADBEEF;
  assign alu_dout2 = (alu_e2 && alu_r2 && alu_addr2 == 2'd2) ? ref_fn(alu_op2, ax2, ay2) : 32'hDEADBEEF;

  // Views of whichever instance is under test.
  logic        c_ready, c_valid, c_err, c_e, c_w, c_r;
  logic [31:0] c_data;
  logic [1:0]  c_op, c_addr;
  logic [15:0] c_din;
  logic [56:0] rpack1;
  assign c_ready = sel ? cmd_ready2 : cmd_ready1;
  assign c_valid = sel ? rsp_valid2 : rsp_valid1;
  assign c_data  = sel ? rsp_data2  : rsp_data1;
  assign c_err   = sel ? rsp_err2   : rsp_err1;
  assign c_e     = sel ? alu_e2     : alu_e1;
  assign c_w     = sel ? alu_w2     : alu_w1;
  assign c_r     = sel ? alu_r2     : alu_r1;
  assign c_op    = sel ? alu_op2    : alu_op1;
  assign c_addr  = sel ? alu_addr2  : alu_addr1;
  assign c_din   = sel ? alu_din2   : alu_din1;
  assign rpack1  = {rsp_valid1, rsp_data1, rsp_err1, alu_e1, alu_op1, alu_din1, alu_addr1, alu_w1, alu_r1};

  // Expected bus trace: X phase, Y phase, read phase.
  function automatic void build_exp(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                                    input int h, input int r);
    exp_q.delete();
    for (int i = 0; i < h; i++) exp_q.push_back({1'b1, op, 1'b1, 1'b0, 2'd0, x});
    for (int i = 0; i < h; i++) exp_q.push_back({1'b1, op, 1'b1, 1'b0, 2'd1, y});
    for (int i = 0; i < r; i++) exp_q.push_back({1'b1, op, 1'b0, 1'b1, 2'd2, 16'd0});
  endfunction

  function automatic logic bus_match();
    if (bus_q.size() != exp_q.size()) return 1'b0;
    foreach (bus_q[i]) if (bus_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Issue one command, trace the bus, capture the response, then complete the handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        output int lat, output logic [31:0] data, output logic err,
                        output int wcnt, output int rcnt);
    @(negedge clk);
    cmd_op = op; cmd_x = x; cmd_y = y; rsp_ready = 1'b0;
    if (sel) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = 2'($urandom); cmd_x = 16'($urandom); cmd_y = 16'($urandom);
    bus_q.delete();
    lat = 0; wcnt = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      if (c_valid || lat > 60) break;
      bus_q.push_back({c_e, c_op, c_w, c_r, c_addr, c_din});
      wcnt += int'(c_w);
      rcnt += int'(c_r);
      lat++;
    end
    data = c_data;
    err  = c_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (rpack1 !== 57'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", rpack1); end
    n_cmp++;
    if ({rsp_valid2, alu_e2, alu_w2, alu_r2} !== 4'b0) begin
      n_fail++; $display("FAIL reset_outputs2: got %b want 0000", {rsp_valid2, alu_e2, alu_w2, alu_r2});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready1); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops[7]  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [15:0] xs[7]   = '{16'd445, 16'd4, 16'd445, 16'd1000, 16'd445, 16'd1000, 16'd7};
    logic [15:0] ys[7]   = '{16'd100, 16'd5, 16'd100, 16'd1000, 16'd100, 16'd250, 16'd0};
    logic [31:0] res[7]  = '{32'd188025, 32'hFFFFFFF7, 32'd45, 32'd1, 32'd100, 32'd250, 32'd0};
    logic        errs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, wc, rc;
    logic [31:0] d;
    logic e;
    sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_cmd(ops[i], xs[i], ys[i], lat, d, e, wc, rc);
      if (errs[i]) exp_q.delete(); else build_exp(ops[i], xs[i], ys[i], 1, 1);
      n_cmp++;
      if (d !== res[i]) begin n_fail++; $display("FAIL dir%0d_data: got %h want %h", i, d, res[i]); end
      n_cmp++;
      if (e !== errs[i]) begin n_fail++; $display("FAIL dir%0d_err: got %b want %b", i, e, errs[i]); end
      n_cmp++;
      if (lat !== (errs[i] ? 0 : 3)) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, errs[i] ? 0 : 3); end
      n_cmp++;
      if (bus_match() !== 1'b1 || wc !== (errs[i] ? 0 : 2) || rc !== (errs[i] ? 0 : 1)) begin
        n_fail++; $display("FAIL dir%0d_bus: got w=%0d r=%0d len=%0d want len=%0d", i, wc, rc, bus_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_random();
    int lat, wc, rc;
    logic [31:0] d;
    logic e, ill;
    logic [1:0] op;
    logic [15:0] x, y;
    sel = 1'b0;
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom_range(0, 3));
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) y = (op == 2'd3) ? x : 16'd0;
      ill = is_illegal(op, x, y);
      do_cmd(op, x, y, lat, d, e, wc, rc);
      if (ill) exp_q.delete(); else build_exp(op, x, y, 1, 1);
      n_cmp++;
      if (d !== (ill ? 32'd0 : ref_fn(op, x, y)) || e !== ill || lat !== (ill ? 0 : 3) || bus_match() !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d op=%0d x=%0d y=%0d: got data=%h err=%b lat=%0d want data=%h err=%b lat=%0d",
                 i, op, x, y, d, e, lat, ill ? 32'd0 : ref_fn(op, x, y), ill, ill ? 0 : 3);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    sel = 1'b0;
    @(negedge clk);
    cmd_op = 2'd1; cmd_x = 16'd445; cmd_y = 16'd100; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid1 && lat < 20);
    for (int i = 0; i < 5; i++) begin
      cmd_op = 2'd0; cmd_x = 16'd4; cmd_y = 16'd5; cmd_valid = 1'b1;
      n_cmp++;
      if (rsp_valid1 !== 1'b1 || rsp_data1 !== 32'd45 || cmd_ready1 !== 1'b0) begin
        n_fail++; $display("FAIL stall%0d: got v=%b d=%0d rdy=%b want v=1 d=45 rdy=0", i, rsp_valid1, rsp_data1, cmd_ready1);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid1 !== 1'b0 || cmd_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL handshake_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid1, cmd_ready1);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid1 || lat > 20) break;
      lat++;
    end
    n_cmp++;
    if (lat !== 3 || rsp_data1 !== 32'hFFFFFFF7 || rsp_err1 !== 1'b0) begin
      n_fail++; $display("FAIL after_stall: got lat=%0d d=%h want lat=3 d=fffffff7", lat, rsp_data1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_long_timing();
    int lat, wc, rc;
    logic [31:0] d;
    logic e;
    sel = 1'b1;
    do_cmd(2'd0, 16'd445, 16'd100, lat, d, e, wc, rc);
    build_exp(2'd0, 16'd445, 16'd100, 3, 2);
    n_cmp++;
    if (wc !== 6 || rc !== 2) begin n_fail++; $display("FAIL long_strobes: got w=%0d r=%0d want w=6 r=2", wc, rc); end
    n_cmp++;
    if (lat !== 8) begin n_fail++; $display("FAIL long_latency: got %0d want 8", lat); end
    n_cmp++;
    if (d !== 32'd188025 || e !== 1'b0 || bus_match() !== 1'b1) begin
      n_fail++; $display("FAIL long_result: got d=%0d err=%b want d=188025 err=0", d, e);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, wc, rc, seen;
    logic [31:0] d;
    logic e;
    sel = 1'b0;
    @(negedge clk);
    cmd_op = 2'd0; cmd_x = 16'd1000; cmd_y = 16'd3; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (alu_addr1 !== 2'd1 || alu_w1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_wr_y: got addr=%0d w=%b want addr=1 w=1", alu_addr1, alu_w1);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (rpack1 !== 57'd0) begin n_fail++; $display("FAIL mid_async_reset: got %h want 0", rpack1); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid1 !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0 || cmd_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_no_response: got valid_cycles=%0d rdy=%b want 0 and 1", seen, cmd_ready1);
    end
    do_cmd(2'd1, 16'd9, 16'd4, lat, d, e, wc, rc);
    n_cmp++;
    if (d !== 32'd1 || e !== 1'b0 || lat !== 3 || wc !== 2 || rc !== 1) begin
      n_fail++; $display("FAIL mid_recover: got d=%0d err=%b lat=%0d w=%0d r=%0d want 1 0 3 2 1", d, e, lat, wc, rc);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_x = 16'd0; cmd_y = 16'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_long_timing();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
